// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin share of the ROM read port between fetch (i) and memory-stage load (d)
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   i_req_valid/addr/ready       fetch request handshake
//   i_resp_valid/data/error      fetch response slot (error = misaligned address)
//   i_resp_ready, i_flush        fetch response consume, fetch slot discard
//   d_*                          same as i_* for the load port, without flush
//   rom_address, rom_data        combinational ROM read port
module rom_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_req_ready,
    output logic                  i_resp_valid,
    output logic [DATA_WIDTH-1:0] i_resp_data,
    output logic                  i_resp_error,
    input  logic                  i_resp_ready,
    input  logic                  i_flush,
    input  logic                  d_req_valid,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    output logic                  d_req_ready,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic                  d_resp_error,
    input  logic                  d_resp_ready,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_data
);
    logic last_i;
    logic i_el, d_el;
    logic err;
    logic [DATA_WIDTH-1:0] word;
    // a slot can take a new word when empty or being drained this cycle
    assign i_el = !reset && !i_flush && i_req_valid && (!i_resp_valid || i_resp_ready);
    assign d_el = !reset && d_req_valid && (!d_resp_valid || d_resp_ready);
    // on a tie the port that did not win last time is granted
    assign i_req_ready = i_el && (!d_el || !last_i);
    assign d_req_ready = d_el && (!i_el || last_i);
    assign rom_address = i_req_ready ? i_req_addr : d_req_ready ? d_req_addr : '0;
    assign err = |rom_address[1:0];
    assign word = err ? '0 : rom_data;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_i       <= 1'b1;
            i_resp_valid <= 1'b0;
            i_resp_data  <= '0;
            i_resp_error <= 1'b0;
            d_resp_valid <= 1'b0;
            d_resp_data  <= '0;
            d_resp_error <= 1'b0;
        end else begin
            if (i_req_ready || d_req_ready) last_i <= i_req_ready;
            if (i_req_ready) begin
                i_resp_valid <= 1'b1;
                i_resp_data  <= word;
                i_resp_error <= err;
            end else if (i_flush || i_resp_ready) begin
                i_resp_valid <= 1'b0;
            end
            if (d_req_ready) begin
                d_resp_valid <= 1'b1;
                d_resp_data  <= word;
                d_resp_error <= err;
            end else if (d_resp_ready) begin
                d_resp_valid <= 1'b0;
            end
        end
    end
endmodule
